reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Multi-channel reset generator. Takes one async active-low board reset, synchronises its release to clk,
//  holds all outputs for a minimum time, then releases NUM_CHANNELS reset outputs in index order with a fixed gap.
//  Sits at the top of each clock domain; feeds the per-subsystem resets (e.g. ch0 = fabric, ch1 = memories, ...).
// PARAMETERS
//  SYNC_STAGES     3   synchroniser flops on the release path (>=2)
//  NUM_CHANNELS    4   number of reset outputs (>=1)
//  MIN_ASSERT      8   cycles all outputs stay asserted after the synchronised release (>=1)
//  RELEASE_GAP     16  cycles between successive channel releases (>=1)
//  OUTPUT_POLARITY 1   1 = rst_o active high, 0 = active low
// PORTS
//  clk             in  1             domain clock
//  async_reset_i   in  1             asynchronous reset, active low
//  sw_reset_req_i  in  1             sync software reset request, 1-cycle pulse (only with RESET_SEQ_SW_REQ_EN)
//  rst_o           out NUM_CHANNELS  per-channel reset, polarity per OUTPUT_POLARITY
//  busy_o          out 1             1 while any channel is asserted
//  all_released_o  out 1             1 once every channel is released
// BEHAVIOUR
//  - Assertion is asynchronous: async_reset_i low immediately (no clock) clears the sync chain and counters,
//    sets FSM=HOLD, asserts all rst_o, busy_o=1, all_released_o=0. These are the reset values.
//  - Release is synchronous: edge 1 = first rising edge with async_reset_i high; sync chain output rises at edge SYNC_STAGES.
//  - FSM: HOLD -> RELEASE -> DONE.
//    HOLD: wait for sync chain output, then count MIN_ASSERT edges; on terminal count release ch0, go to RELEASE.
//    RELEASE: gap counter counts RELEASE_GAP edges; on terminal count release next channel;
//    releasing ch NUM_CHANNELS-1 -> DONE.
//    With NUM_CHANNELS=1, HOLD goes directly to DONE.
//    DONE: all released; stays until async reset or sw request.
//  - Timing: rst_o[i] deasserts at edge SYNC_STAGES+MIN_ASSERT+i*RELEASE_GAP.
//    all_released_o and busy_o change on the same edge as the last release.
//  - Released channels stay released; rst_o is a registered thermometer (once ch i is released, all ch <i are released).
//  - Counter width = $clog2(max(MIN_ASSERT,RELEASE_GAP)+1). Counters saturate, never wrap.
//  - Async reset mid-sequence (any state) or glitch shorter than a clock period:
//    full immediate reassertion, then a complete replay from edge 1.
//  - Illegal parameters (below the minima) -> elaboration-time $error.
// CONFIGURATION
//  RESET_SEQ_SW_REQ_EN defined: sw_reset_req_i port exists.
//    Request sampled high in DONE or RELEASE -> all rst_o reasserted on that edge, FSM=HOLD with the sync chain
//    bypassed, and rst_o[i] deasserts MIN_ASSERT+i*RELEASE_GAP edges after the request edge.
//    Request in HOLD is ignored. Async reset has priority over the request.
//  RESET_SEQ_SW_REQ_EN undefined: port absent; the internal request is tied to 0.
// STRUCTURE
//  reset_seq_pkg: state_t enum {HOLD, RELEASE, DONE}; cnt_width() function; parameter-check helper.
//  Sub-module reset_sync_chain #(STAGES): async-assert, sync-deassert flop chain, active-low in/out.
//    Instantiated once.
//  Top: FSM, saturating counter, channel index, output register with polarity XOR at the output only.
// TESTING (defaults unless stated)
//  1. async_reset_i low 5 cycles then high -> rst_o=4'b1111 while low; rst_o[0..3] drop at edges 11/27/43/59;
//     all_released_o=1 and busy_o=0 at edge 59.
//  2. async_reset_i pulsed low 2ns between edges 30 and 31 (ch1 already released) -> rst_o=4'b1111 before edge 31;
//     full replay with rst_o[0] dropping 11 edges after release.
//  3. RESET_SEQ_SW_REQ_EN, 1-cycle request in DONE at edge E -> rst_o=1111 at E;
//     ch0..3 drop at E+8/E+24/E+40/E+56. Repeat with the request in HOLD -> no effect.
//  4. OUTPUT_POLARITY=0 -> rst_o=4'b0000 in reset; bits rise at the same edges as scenario 1.
//  5. NUM_CHANNELS=1, RELEASE_GAP=1, MIN_ASSERT=1, SYNC_STAGES=2 -> rst_o drops at edge 3;
//     all_released_o=1 on the same edge.
//  6. Async reset and sw request on the same edge -> async reset wins; sequence replays from edge 1.

Source files
------------

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_seq_pkg : shared state encoding and elaboration helpers for reset_sequencer
// Revision      : 1.0
// ----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int cnt_width(input int min_assert, input int release_gap);
    int longest;
    longest = (min_assert > release_gap) ? min_assert : release_gap;
    return $clog2(longest + 1);
  endfunction

  function automatic bit params_ok(input int sync_stages, input int num_channels,
                                   input int min_assert, input int release_gap,
                                   input int output_polarity);
    return (sync_stages >= 2) && (num_channels >= 1) && (min_assert >= 1) &&
           (release_gap >= 1) && (output_polarity == 0 || output_polarity == 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_sync_chain : async-assert / sync-deassert flop chain, active-low in and out
// Revision         : 1.0
// ----------------------------------------------------------------------------
module reset_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = stages[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_sequencer : staged multi-channel reset release; optional software
//                   re-sequence request enabled by RESET_SEQ_SW_REQ_EN
// Revision        : 1.0
// ----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int NUM_CHANNELS    = 4,
  parameter int MIN_ASSERT      = 8,
  parameter int RELEASE_GAP     = 16,
  parameter int OUTPUT_POLARITY = 1
) (
  input  logic                    clk,
  input  logic                    async_reset_i,
`ifdef RESET_SEQ_SW_REQ_EN
  input  logic                    sw_reset_req_i,
`endif
  output logic [NUM_CHANNELS-1:0] rst_o,
  output logic                    busy_o,
  output logic                    all_released_o
);

  localparam int CNT_W = cnt_width(MIN_ASSERT, RELEASE_GAP);
  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [NUM_CHANNELS-1:0] POL_MASK = (OUTPUT_POLARITY == 0) ? '1 : '0;

  if (!params_ok(SYNC_STAGES, NUM_CHANNELS, MIN_ASSERT, RELEASE_GAP, OUTPUT_POLARITY))
  begin : g_param_check
    $error("reset_sequencer: illegal parameter set");
  end

  logic sw_req;
`ifdef RESET_SEQ_SW_REQ_EN
  assign sw_req = sw_reset_req_i;
`else
  assign sw_req = 1'b0;
`endif

  logic sync_rst_n;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (async_reset_i),
    .sync_rst_n (sync_rst_n)
  );

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [NUM_CHANNELS-1:0] asserted, asserted_n;

  always_ff @(posedge clk or negedge async_reset_i) begin
    if (!async_reset_i) begin
      state    <= HOLD;
      cnt      <= '0;
      idx      <= '0;
      asserted <= '1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      asserted <= asserted_n;
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // The sync chain stays high after a software request, so HOLD needs no explicit bypass.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    asserted_n = asserted;
    case (state)
      HOLD: begin
        if (sync_rst_n) begin
          cnt_n = cnt_inc;
          if (cnt == HOLD_LAST) begin
            asserted_n = asserted << 1;
            cnt_n      = '0;
            idx_n      = IDX_W'(1);
            state_n    = (NUM_CHANNELS == 1) ? DONE : RELEASE;
          end
        end
      end
      RELEASE: begin
        if (sw_req) begin
          asserted_n = '1;
          cnt_n      = '0;
          idx_n      = '0;
          state_n    = HOLD;
        end else begin
          cnt_n = cnt_inc;
          if (cnt == GAP_LAST) begin
            asserted_n = asserted << 1;
            cnt_n      = '0;
            if (idx == LAST_IDX) begin
              state_n = DONE;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
        end
      end
      DONE: begin
        if (sw_req) begin
          asserted_n = '1;
          cnt_n      = '0;
          idx_n      = '0;
          state_n    = HOLD;
        end
      end
      default: begin
        asserted_n = '1;
        cnt_n      = '0;
        idx_n      = '0;
        state_n    = HOLD;
      end
    endcase
  end

  // Thermometer release order means the top channel alone tells whether anything is still held.
  assign rst_o          = asserted ^ POL_MASK;
  assign busy_o         = asserted[NUM_CHANNELS-1];
  assign all_released_o = ~asserted[NUM_CHANNELS-1];

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reset_sequencer : scoreboard bench for reset_sequencer (default, inverted-polarity
//                      and minimal single-channel instances share clock and board reset)
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       busy;
    logic       all;
  } exp_t;

  logic       clk;
  logic       async_n;
  logic [3:0] rst_main, rst_pol;
  logic       rst_one;
  logic       busy_main, all_main, busy_pol, all_pol, busy_one, all_one;
`ifdef RESET_SEQ_SW_REQ_EN
  logic       sw_req;
`endif

  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q_main[$];
  exp_t q_pol[$];
  exp_t q_one[$];

  reset_sequencer u_main (
    .clk            (clk),
    .async_reset_i  (async_n),
`ifdef RESET_SEQ_SW_REQ_EN
    .sw_reset_req_i (sw_req),
`endif
    .rst_o          (rst_main),
    .busy_o         (busy_main),
    .all_released_o (all_main)
  );

  reset_sequencer #(.OUTPUT_POLARITY(0)) u_pol (
    .clk            (clk),
    .async_reset_i  (async_n),
`ifdef RESET_SEQ_SW_REQ_EN
    .sw_reset_req_i (sw_req),
`endif
    .rst_o          (rst_pol),
    .busy_o         (busy_pol),
    .all_released_o (all_pol)
  );

  reset_sequencer #(.SYNC_STAGES(2), .NUM_CHANNELS(1), .MIN_ASSERT(1), .RELEASE_GAP(1)) u_one (
    .clk            (clk),
    .async_reset_i  (async_n),
`ifdef RESET_SEQ_SW_REQ_EN
    .sw_reset_req_i (sw_req),
`endif
    .rst_o          (rst_one),
    .busy_o         (busy_one),
    .all_released_o (all_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int id, input int c, input logic [3:0] r, input logic b, input logic a);
    exp_t e;
    e.cyc = c; e.rst = r; e.busy = b; e.all = a;
    case (id)
      0:       q_main.push_back(e);
      1:       q_pol.push_back(e);
      default: q_one.push_back(e);
    endcase
  endtask

  task automatic push_reset(input int c);
    push(0, c, 4'b1111, 1'b1, 1'b0);
    push(1, c, 4'b0000, 1'b1, 1'b0);
    push(2, c, 4'b0001, 1'b1, 1'b0);
  endtask

  // Four-channel releases at base+ofs+16*i; only the first n are expected to occur.
  task automatic push_seq(input int base, input int ofs, input int n);
    logic [3:0] v;
    for (int i = 0; i < n; i++) begin
      v = 4'b1111 << (i + 1);
      push(0, base + ofs + 16 * i, v, i != 3, i == 3);
      push(1, base + ofs + 16 * i, ~v, i != 3, i == 3);
    end
  endtask

  task automatic chk(input int id, input logic [3:0] r, input logic b, input logic a);
    exp_t  e;
    bit    have;
    string nm;
    have = 1'b0;
    nm   = (id == 0) ? "main" : (id == 1) ? "pol0" : "one";
    case (id)
      0:       if (q_main.size() > 0) begin e = q_main.pop_front(); have = 1'b1; end
      1:       if (q_pol.size() > 0)  begin e = q_pol.pop_front();  have = 1'b1; end
      default: if (q_one.size() > 0)  begin e = q_one.pop_front();  have = 1'b1; end
    endcase
    n_checks++;
    if (!have) begin
      $display("FAIL %s unexpected_change cyc=%0d got rst=%b busy=%b all=%b, required no change",
               nm, cyc, r, b, a);
    end else if (e.cyc != cyc || e.rst !== r || e.busy !== b || e.all !== a) begin
      $display("FAIL %s change cyc=%0d got rst=%b busy=%b all=%b, required cyc=%0d rst=%b busy=%b all=%b",
               nm, cyc, r, b, a, e.cyc, e.rst, e.busy, e.all);
    end else begin
      n_pass++;
    end
  endtask

  task automatic flush_missing();
    exp_t e;
    while (q_main.size() > 0) begin
      e = q_main.pop_front(); n_checks++;
      $display("FAIL main missing_change got none by cyc=%0d, required cyc=%0d rst=%b", cyc, e.cyc, e.rst);
    end
    while (q_pol.size() > 0) begin
      e = q_pol.pop_front(); n_checks++;
      $display("FAIL pol0 missing_change got none by cyc=%0d, required cyc=%0d rst=%b", cyc, e.cyc, e.rst);
    end
    while (q_one.size() > 0) begin
      e = q_one.pop_front(); n_checks++;
      $display("FAIL one missing_change got none by cyc=%0d, required cyc=%0d rst=%b", cyc, e.cyc, e.rst);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    flush_missing();
  endtask

  // Monitors: the first pop checks the reset state, later pops fire on every output change.
  initial begin
    #3;
    chk(0, rst_main, busy_main, all_main);
    forever begin
      @(rst_main or busy_main or all_main);
      #1;
      chk(0, rst_main, busy_main, all_main);
    end
  end

  initial begin
    #3;
    chk(1, rst_pol, busy_pol, all_pol);
    forever begin
      @(rst_pol or busy_pol or all_pol);
      #1;
      chk(1, rst_pol, busy_pol, all_pol);
    end
  end

  initial begin
    #3;
    chk(2, {3'b000, rst_one}, busy_one, all_one);
    forever begin
      @(rst_one or busy_one or all_one);
      #1;
      chk(2, {3'b000, rst_one}, busy_one, all_one);
    end
  end

  initial begin
    int base;
    async_n = 1'b1;
`ifdef RESET_SEQ_SW_REQ_EN
    sw_req  = 1'b0;
`endif
    push_reset(0);
    #1 async_n = 1'b0;

    // Power-on reset, then a normal release
    repeat (5) @(negedge clk);
    #1;
    base = cyc;
    push_seq(base, 11, 4);
    push(2, base + 3, 4'b0000, 1'b0, 1'b1);
    async_n = 1'b1;
    settle(70);

    // Short glitch after ch1 released: immediate reassertion and full replay
    @(negedge clk); #1;
    push_reset(cyc);
    async_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    base = cyc;
    push_seq(base, 11, 2);
    push(2, base + 3, 4'b0000, 1'b0, 1'b1);
    async_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    push_reset(cyc);
    base = cyc;
    push_seq(base, 11, 4);
    push(2, base + 3, 4'b0000, 1'b0, 1'b1);
    async_n = 1'b0;
    #2 async_n = 1'b1;
    settle(70);

`ifdef RESET_SEQ_SW_REQ_EN
    // Software request while DONE
    @(negedge clk); #1;
    base = cyc + 1;
    push_reset(base);
    push_seq(base, 8, 4);
    push(2, base + 1, 4'b0000, 1'b0, 1'b1);
    sw_req = 1'b1;
    @(negedge clk); #1 sw_req = 1'b0;
    settle(70);

    // Software request while HOLD is ignored
    @(negedge clk); #1;
    push_reset(cyc);
    async_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    base = cyc;
    push_seq(base, 11, 4);
    push(2, base + 3, 4'b0000, 1'b0, 1'b1);
    async_n = 1'b1;
    @(negedge clk); #1 sw_req = 1'b1;
    @(negedge clk); #1 sw_req = 1'b0;
    settle(70);

    // Board reset and software request together: board reset wins
    @(negedge clk); #1;
    push_reset(cyc);
    async_n = 1'b0;
    sw_req  = 1'b1;
    @(negedge clk); #1 sw_req = 1'b0;
    @(negedge clk); #1;
    base = cyc;
    push_seq(base, 11, 4);
    push(2, base + 3, 4'b0000, 1'b0, 1'b1);
    async_n = 1'b1;
    settle(70);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
